// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the 8-line interrupt controller:
// command codes on the command/status port and the request FSM encoding.
package irq_ctrl_pkg;

    // Non-specific end-of-interrupt: retire the highest-priority in-service IRQ.
    localparam logic [7:0] CMD_EOI_NS        = 8'h20;
    // Specific end-of-interrupt: 8'h6n retires IRQn; low three bits carry n.
    localparam logic [7:0] CMD_EOI_SPEC      = 8'h60;
    localparam logic [7:0] CMD_EOI_SPEC_MASK = 8'hF8;
    // Status-read select commands.
    localparam logic [7:0] CMD_RD_IRR        = 8'h0A;
    localparam logic [7:0] CMD_RD_ISR        = 8'h0B;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    typedef enum logic {
        RSEL_IRR = 1'b0,
        RSEL_ISR = 1'b1
    } rsel_t;

endpackage

// File: rtl/irq_ctrl_prio8.sv
// Combinational 8-bit lowest-set-bit encoder; bit 0 has highest priority.
module irq_prio8 (
    input  logic [7:0] req_i,
    output logic       found_o,
    output logic [2:0] idx_o
);

    // Scan downwards so the lowest-numbered set bit is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Eight-input priority interrupt controller with mask, in-service tracking,
// nesting of higher-priority requests and EOI commands.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [7:0] VECTOR_BASE = 8'h08
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] irq_in,
    output logic       irq_signal,
    output logic [7:0] irq_id,
    input  logic       irq_ack,
    input  logic       port_a0,
    input  logic       port_we,
    input  logic [7:0] port_wdata,
    output logic [7:0] port_rdata
);

    logic [7:0] sync1_q, sync2_q, prev_q;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] imr_q, imr_d;
    logic [2:0] cur_q, cur_d;
    state_t     state_q, state_d;
    rsel_t      rsel_q, rsel_d;

    logic [7:0] edge_det;
    logic       cand_found, isr_found;
    logic [2:0] cand_idx, isr_idx;
    logic       eligible;
    logic       ack_take;
    logic       cmd_wr, eoi_ns, eoi_sp;

    // Rising edge of the synchronized line; a held-high line produces one pulse.
    assign edge_det = sync2_q & ~prev_q;

    irq_prio8 u_cand_prio (
        .req_i   (irr_q & ~imr_q),
        .found_o (cand_found),
        .idx_o   (cand_idx)
    );

    irq_prio8 u_isr_prio (
        .req_i   (isr_q),
        .found_o (isr_found),
        .idx_o   (isr_idx)
    );

    // Only strictly higher priority than everything in service may interrupt.
    assign eligible = cand_found && (!isr_found || (cand_idx < isr_idx));

    assign cmd_wr = port_we && !port_a0;
    assign eoi_ns = cmd_wr && (port_wdata == CMD_EOI_NS);
    assign eoi_sp = cmd_wr && ((port_wdata & CMD_EOI_SPEC_MASK) == CMD_EOI_SPEC);

    // Request FSM: latch the winner in IDLE, hold it stable while pending.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        ack_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    cur_d   = cand_idx;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // A mask or vanished IRR bit withdraws the request before any ack.
                if (imr_q[cur_q] || !irr_q[cur_q]) begin
                    state_d = ST_IDLE;
                end else if (irq_ack) begin
                    ack_take = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register next-state: ack clears IRR before new edges set it, EOI
    // retires from the old ISR before the ack sets the new bit.
    always_comb begin
        irr_d = irr_q;
        if (ack_take) irr_d[cur_q] = 1'b0;
        irr_d = irr_d | edge_det;

        isr_d = isr_q;
        if (eoi_ns && isr_found) isr_d[isr_idx] = 1'b0;
        if (eoi_sp) isr_d[port_wdata[2:0]] = 1'b0;
        if (ack_take) isr_d[cur_q] = 1'b1;

        imr_d = (port_we && port_a0) ? port_wdata : imr_q;

        rsel_d = rsel_q;
        if (cmd_wr && (port_wdata == CMD_RD_IRR)) rsel_d = RSEL_IRR;
        if (cmd_wr && (port_wdata == CMD_RD_ISR)) rsel_d = RSEL_ISR;
    end

    // Two-flop synchronizer plus previous-value flop for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
            prev_q  <= 8'h00;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Controller state: request/service/mask registers, FSM and read select.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irr_q   <= 8'h00;
            isr_q   <= 8'h00;
            imr_q   <= 8'hFF;
            cur_q   <= 3'd0;
            state_q <= ST_IDLE;
            rsel_q  <= RSEL_IRR;
        end else begin
            irr_q   <= irr_d;
            isr_q   <= isr_d;
            imr_q   <= imr_d;
            cur_q   <= cur_d;
            state_q <= state_d;
            rsel_q  <= rsel_d;
        end
    end

    // Vector wraps modulo 256 by the 8-bit add.
    assign irq_signal = (state_q == ST_PEND);
    assign irq_id     = VECTOR_BASE + {5'b00000, cur_q};
    assign port_rdata = port_a0 ? imr_q : ((rsel_q == RSEL_ISR) ? isr_q : irr_q);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl.
module tb_irq_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       irq_signal;
    logic [7:0] irq_id;
    logic       irq_ack;
    logic       port_a0;
    logic       port_we;
    logic [7:0] port_wdata;
    logic [7:0] port_rdata;

    int n_pass  = 0;
    int n_total = 0;

    irq_ctrl #(.VECTOR_BASE(8'h08)) dut (
        .clock      (clock),
        .reset      (reset),
        .irq_in     (irq_in),
        .irq_signal (irq_signal),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .port_a0    (port_a0),
        .port_we    (port_we),
        .port_wdata (port_wdata),
        .port_rdata (port_rdata)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic a0, input logic [7:0] d);
        port_a0    = a0;
        port_wdata = d;
        port_we    = 1'b1;
        tick();
        port_we    = 1'b0;
    endtask

    task automatic rd(input logic a0, output logic [7:0] d);
        port_a0 = a0;
        #1;
        d = port_rdata;
    endtask

    task automatic rd_sel(input logic [7:0] cmd, output logic [7:0] d);
        wr(1'b0, cmd);
        rd(1'b0, d);
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    // Bounded wait for a request, then check it carries the expected vector.
    task automatic wait_sig(input string tag, input logic [7:0] exp_id, output int cyc);
        cyc = 0;
        while (!irq_signal && cyc < 8) begin
            tick();
            cyc++;
        end
        chk({tag, "_sig"}, {7'd0, irq_signal}, 8'h01);
        chk({tag, "_id"}, irq_id, exp_id);
    endtask

    initial begin
        logic [7:0] d;
        int cyc;

        reset = 1'b1; irq_in = 8'h00; irq_ack = 1'b0;
        port_a0 = 1'b0; port_we = 1'b0; port_wdata = 8'h00;
        tick(); tick();

        // Reset state
        chk("rst_sig", {7'd0, irq_signal}, 8'h00);
        chk("rst_id", irq_id, 8'h08);
        rd(1'b1, d); chk("rst_imr", d, 8'hFF);
        rd(1'b0, d); chk("rst_irr", d, 8'h00);
        reset = 1'b0;
        tick();

        // Ack in IDLE is ignored
        ack();
        rd_sel(8'h0B, d); chk("idle_ack_isr", d, 8'h00);

        // Single unmasked IRQ0
        wr(1'b1, 8'hFE);
        irq_in = 8'h01;
        wait_sig("t34", 8'h08, cyc);
        chk("t34_lat_le4", {7'd0, (cyc <= 4)}, 8'h01);
        irq_in = 8'h00;
        ack();
        chk("t34_drop", {7'd0, irq_signal}, 8'h00);
        rd_sel(8'h0B, d); chk("t34_isr", d, 8'h01);
        rd_sel(8'h0A, d); chk("t34_irr", d, 8'h00);
        wr(1'b0, 8'h20);
        rd_sel(8'h0B, d); chk("t34_eoi_isr", d, 8'h00);

        // Simultaneous IRQ3 and IRQ1: IRQ1 first, IRQ3 after EOI
        wr(1'b1, 8'h00);
        irq_in = 8'h0A;
        wait_sig("t35a", 8'h09, cyc);
        irq_in = 8'h00;
        ack();
        tick();
        chk("t35_wait", {7'd0, irq_signal}, 8'h00);
        wr(1'b0, 8'h20);
        wait_sig("t35b", 8'h0B, cyc);
        ack();

        // IRQ3 in service: IRQ5 blocked, IRQ2 nests
        irq_in = 8'h20; tick(); tick(); tick();
        irq_in = 8'h00; tick(); tick(); tick();
        chk("t36_blk5", {7'd0, irq_signal}, 8'h00);
        rd_sel(8'h0A, d); chk("t36_irr5", d, 8'h20);
        irq_in = 8'h04;
        wait_sig("t36_nest2", 8'h0A, cyc);
        irq_in = 8'h00;
        ack();
        rd_sel(8'h0B, d); chk("t36_isr", d, 8'h0C);
        wr(1'b0, 8'h20);
        tick();
        chk("t36_one_eoi", {7'd0, irq_signal}, 8'h00);
        wr(1'b0, 8'h20);
        wait_sig("t36_irq5", 8'h0D, cyc);
        ack();
        wr(1'b0, 8'h65);
        rd_sel(8'h0B, d); chk("t36_spec_eoi", d, 8'h00);

        // Masking withdraws a pending IRQ4
        irq_in = 8'h10;
        wait_sig("t37a", 8'h0C, cyc);
        irq_in = 8'h00;
        wr(1'b1, 8'h10);
        tick();
        chk("t37_withdraw", {7'd0, irq_signal}, 8'h00);
        rd_sel(8'h0B, d); chk("t37_isr", d, 8'h00);
        rd_sel(8'h0A, d); chk("t37_irr", d, 8'h10);
        wr(1'b1, 8'h00);
        wait_sig("t37b", 8'h0C, cyc);
        ack();
        wr(1'b0, 8'h20);

        // New IRQ6 edge lands on the same edge as the IRQ6 ack
        irq_in = 8'h40;
        wait_sig("t38a", 8'h0E, cyc);
        irq_in = 8'h00;
        tick(); tick(); tick();
        irq_in = 8'h40;
        tick(); tick();
        ack();
        chk("t38_drop", {7'd0, irq_signal}, 8'h00);
        rd_sel(8'h0A, d); chk("t38_irr", d, 8'h40);
        rd_sel(8'h0B, d); chk("t38_isr", d, 8'h40);
        irq_in = 8'h00;
        wr(1'b0, 8'h20);
        wait_sig("t38b", 8'h0E, cyc);

        // Reset during PEND
        reset = 1'b1;
        #1;
        chk("t39_sig", {7'd0, irq_signal}, 8'h00);
        chk("t39_id", irq_id, 8'h08);
        rd(1'b1, d); chk("t39_imr", d, 8'hFF);
        tick();
        reset = 1'b0;
        rd(1'b0, d); chk("t39_irr", d, 8'h00);
        rd_sel(8'h0B, d); chk("t39_isr", d, 8'h00);
        tick(); tick();
        chk("t39_no_req", {7'd0, irq_signal}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
